// File: rtl/bp_fe_fetch_buffer_ctrl.sv
// bp_fe_fetch_buffer_ctrl: halfword fetch buffer presenting a scan window with 32-bit partial detection
module bp_fe_fetch_buffer_ctrl #(
  parameter int fetch_cinstr_p = 4,
  parameter int buf_els_p = 8,
  parameter int vaddr_width_p = 39,
  localparam int ptr_width_lp = $clog2(fetch_cinstr_p+1),
  localparam int idx_width_lp = $clog2(buf_els_p),
  localparam int occ_width_lp = $clog2(buf_els_p+1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        redirect_i,
  input  logic                        fetch_v_i,
  output logic                        fetch_ready_and_o,
  input  logic [vaddr_width_p-1:0]    fetch_pc_i,
  input  logic [16*fetch_cinstr_p-1:0] fetch_data_i,
  input  logic [ptr_width_lp-1:0]     fetch_count_i,
  output logic                        scan_v_o,
  output logic [vaddr_width_p-1:0]    scan_pc_o,
  output logic [16*fetch_cinstr_p-1:0] scan_instr_o,
  output logic [ptr_width_lp-1:0]     scan_count_o,
  output logic [ptr_width_lp-1:0]     scan_partial_o,
  input  logic [ptr_width_lp-1:0]     scan_yumi_i,
  output logic [occ_width_lp-1:0]     occupancy_o
);
  logic [15:0] mem [buf_els_p];
  logic [idx_width_lp-1:0] rd_ptr, wr_ptr;
  logic [occ_width_lp-1:0] occ;
  logic [vaddr_width_p-1:0] head_pc;
  logic empty_pc_v;
  logic enq, skip, dangle;
  logic [ptr_width_lp-1:0] enq_cnt;
  logic [15:0] par;
  assign fetch_ready_and_o = (occ_width_lp'(buf_els_p) - occ) >= occ_width_lp'(fetch_cinstr_p);
  assign enq = fetch_v_i & fetch_ready_and_o & ~redirect_i;
  assign enq_cnt = enq ? fetch_count_i : '0;
  assign scan_count_o = occ >= occ_width_lp'(fetch_cinstr_p) ? ptr_width_lp'(fetch_cinstr_p) : ptr_width_lp'(occ);
  assign scan_partial_o = scan_count_o - ptr_width_lp'(dangle);
  assign scan_v_o = scan_partial_o != '0;
  assign scan_pc_o = head_pc;
  assign occupancy_o = occ;
  // A low half starting a 32-bit instruction swallows the next parcel; if none is left it dangles
  always_comb begin
    scan_instr_o = '0;
    skip = 1'b0;
    dangle = 1'b0;
    par = '0;
    for (int k = 0; k < fetch_cinstr_p; k++) begin
      if (ptr_width_lp'(k) < scan_count_o) begin
        par = mem[rd_ptr + idx_width_lp'(k)];
        scan_instr_o[16*k+:16] = par;
        if (skip) skip = 1'b0;
        else if (par[1:0] == 2'b11) begin
          if (ptr_width_lp'(k+1) == scan_count_o) dangle = 1'b1;
          else skip = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      head_pc <= '0;
      empty_pc_v <= 1'b1;
      for (int i = 0; i < buf_els_p; i++) mem[i] <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      empty_pc_v <= 1'b1;
    end else begin
      for (int k = 0; k < fetch_cinstr_p; k++)
        if (enq && ptr_width_lp'(k) < fetch_count_i) mem[wr_ptr + idx_width_lp'(k)] <= fetch_data_i[16*k+:16];
      wr_ptr <= wr_ptr + idx_width_lp'(enq_cnt);
      rd_ptr <= rd_ptr + idx_width_lp'(scan_yumi_i);
      occ <= occ + occ_width_lp'(enq_cnt) - occ_width_lp'(scan_yumi_i);
      if (enq && empty_pc_v) begin
        head_pc <= fetch_pc_i;
        empty_pc_v <= 1'b0;
      end else head_pc <= head_pc + vaddr_width_p'({scan_yumi_i, 1'b0});
    end
  end
  a_fetch_pc: assert property (@(posedge clk_i) disable iff (reset_i)
    (enq && !empty_pc_v) |-> fetch_pc_i == head_pc + vaddr_width_p'({occ, 1'b0}));
  a_yumi_cnt: assert property (@(posedge clk_i) disable iff (reset_i) scan_yumi_i <= scan_count_o);
  a_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i) (scan_yumi_i != '0) |-> scan_v_o);
endmodule

// File: tb/tb_bp_fe_fetch_buffer_ctrl.sv
// tb_bp_fe_fetch_buffer_ctrl: directed scoreboard bench for the fetch buffer controller
module tb_bp_fe_fetch_buffer_ctrl;
  typedef struct {
    logic [3:0]  occ;
    logic        rdy;
    logic        v;
    logic [2:0]  cnt;
    logic [2:0]  part;
    logic [38:0] pc;
    logic [63:0] instr;
    logic        pc_chk;
  } exp_t;
  logic clk_i = 0, reset_i = 1, redirect_i = 0, fetch_v_i = 0;
  logic [38:0] fetch_pc_i = '0;
  logic [63:0] fetch_data_i = '0;
  logic [2:0] fetch_count_i = '0, scan_yumi_i = '0;
  logic fetch_ready_and_o, scan_v_o;
  logic [38:0] scan_pc_o;
  logic [63:0] scan_instr_o;
  logic [2:0] scan_count_o, scan_partial_o;
  logic [3:0] occupancy_o;
  int checks = 0, failures = 0;
  exp_t q[$];
  bp_fe_fetch_buffer_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .redirect_i(redirect_i),
    .fetch_v_i(fetch_v_i), .fetch_ready_and_o(fetch_ready_and_o),
    .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i), .fetch_count_i(fetch_count_i),
    .scan_v_o(scan_v_o), .scan_pc_o(scan_pc_o), .scan_instr_o(scan_instr_o),
    .scan_count_o(scan_count_o), .scan_partial_o(scan_partial_o),
    .scan_yumi_i(scan_yumi_i), .occupancy_o(occupancy_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [63:0] pk(logic [15:0] a3, logic [15:0] a2, logic [15:0] a1, logic [15:0] a0);
    return {a3, a2, a1, a0};
  endfunction
  function automatic exp_t mk(logic [3:0] occ, logic rdy, logic v, logic [2:0] cnt, logic [2:0] part,
                              logic [38:0] pc, logic [63:0] instr, logic pc_chk);
    exp_t e;
    e.occ = occ; e.rdy = rdy; e.v = v; e.cnt = cnt; e.part = part;
    e.pc = pc; e.instr = instr; e.pc_chk = pc_chk;
    return e;
  endfunction
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endfunction
  always @(negedge clk_i) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("occupancy", 64'(occupancy_o), 64'(e.occ));
      chk("ready", 64'(fetch_ready_and_o), 64'(e.rdy));
      chk("scan_v", 64'(scan_v_o), 64'(e.v));
      chk("scan_count", 64'(scan_count_o), 64'(e.cnt));
      chk("scan_partial", 64'(scan_partial_o), 64'(e.part));
      chk("scan_instr", scan_instr_o, e.instr);
      if (e.pc_chk) chk("scan_pc", 64'(scan_pc_o), 64'(e.pc));
    end
  end
  task automatic step(input logic fv, input logic [38:0] pc, input logic [63:0] data, input logic [2:0] cnt,
                      input logic [2:0] yumi, input logic redir, input exp_t e);
    fetch_v_i = fv; fetch_pc_i = pc; fetch_data_i = data; fetch_count_i = cnt;
    scan_yumi_i = yumi; redirect_i = redir;
    @(posedge clk_i);
    #1 q.push_back(e);
    @(negedge clk_i);
    #1;
    fetch_v_i = 0; scan_yumi_i = '0; redirect_i = 0;
  endtask
  initial begin
    #1 q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    #1 reset_i = 0;
    // compressed stream
    step(1, 'h1000, pk(16'h4440, 16'h3330, 16'h2220, 16'h1110), 4, 0, 0,
         mk(4, 1, 1, 4, 4, 'h1000, pk(16'h4440, 16'h3330, 16'h2220, 16'h1110), 1));
    step(0, 0, 0, 0, 4, 0, mk(0, 1, 0, 0, 0, 'h1008, 0, 1));
    // dangling 32-bit low half, completed by the next fetch across the wrap
    step(1, 'h1008, pk(16'h8883, 16'h7770, 16'h6660, 16'h5550), 4, 0, 0,
         mk(4, 1, 1, 4, 3, 'h1008, pk(16'h8883, 16'h7770, 16'h6660, 16'h5550), 1));
    step(0, 0, 0, 0, 3, 0, mk(1, 1, 0, 1, 0, 'h100E, pk(0, 0, 0, 16'h8883), 1));
    step(1, 'h1010, pk(16'hCCC0, 16'hBBB0, 16'hAAA0, 16'h9990), 4, 0, 0,
         mk(5, 0, 1, 4, 4, 'h100E, pk(16'hBBB0, 16'hAAA0, 16'h9990, 16'h8883), 1));
    step(0, 0, 0, 0, 2, 0, mk(3, 1, 1, 3, 3, 'h1012, pk(0, 16'hCCC0, 16'hBBB0, 16'hAAA0), 1));
    // fill to full, then backpressure
    step(1, 'h1018, pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1230), 1, 0, 0,
         mk(4, 1, 1, 4, 4, 'h1012, pk(16'h1230, 16'hCCC0, 16'hBBB0, 16'hAAA0), 1));
    step(1, 'h101A, pk(16'h0450, 16'hF003, 16'hE000, 16'hD000), 4, 0, 0,
         mk(8, 0, 1, 4, 4, 'h1012, pk(16'h1230, 16'hCCC0, 16'hBBB0, 16'hAAA0), 1));
    step(1, 'h102A, pk(16'hBAD0, 16'hBAD0, 16'hBAD0, 16'hBAD0), 4, 0, 0,
         mk(8, 0, 1, 4, 4, 'h1012, pk(16'h1230, 16'hCCC0, 16'hBBB0, 16'hAAA0), 1));
    step(0, 0, 0, 0, 4, 0, mk(4, 1, 1, 4, 4, 'h101A, pk(16'h0450, 16'hF003, 16'hE000, 16'hD000), 1));
    // bring rd_ptr to 6 with occupancy 4
    step(0, 0, 0, 0, 1, 0, mk(3, 1, 1, 3, 3, 'h101C, pk(0, 16'h0450, 16'hF003, 16'hE000), 1));
    step(1, 'h1022, pk(0, 0, 0, 16'h5670), 1, 0, 0,
         mk(4, 1, 1, 4, 4, 'h101C, pk(16'h5670, 16'h0450, 16'hF003, 16'hE000), 1));
    // simultaneous enqueue 4 / dequeue 2 with wrap
    step(1, 'h1024, pk(16'h0400, 16'h0300, 16'h0203, 16'h0100), 4, 2, 0,
         mk(6, 0, 1, 4, 3, 'h1020, pk(16'h0203, 16'h0100, 16'h5670, 16'h0450), 1));
    step(0, 0, 0, 0, 3, 0, mk(3, 1, 1, 3, 3, 'h1026, pk(0, 16'h0400, 16'h0300, 16'h0203), 1));
    step(1, 'h102C, pk(0, 16'h0700, 16'h0600, 16'h0500), 3, 0, 0,
         mk(6, 0, 1, 4, 4, 'h1026, pk(16'h0500, 16'h0400, 16'h0300, 16'h0203), 1));
    step(0, 0, 0, 0, 2, 0, mk(4, 1, 1, 4, 4, 'h102A, pk(16'h0700, 16'h0600, 16'h0500, 16'h0400), 1));
    // redirect collides with fetch and dequeue
    step(1, 'h3000, pk(16'h1110, 16'h1110, 16'h1110, 16'h1110), 4, 2, 1, mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(1, 'h2000, pk(16'h4000, 16'h3000, 16'h2000, 16'h1000), 4, 0, 0,
         mk(4, 1, 1, 4, 4, 'h2000, pk(16'h4000, 16'h3000, 16'h2000, 16'h1000), 1));
    step(1, 'h2008, pk(0, 0, 16'h6000, 16'h5000), 2, 0, 0,
         mk(6, 0, 1, 4, 4, 'h2000, pk(16'h4000, 16'h3000, 16'h2000, 16'h1000), 1));
    // asynchronous reset between edges with 6 parcels held
    @(posedge clk_i);
    #2 reset_i = 1;
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    #1 reset_i = 0;
    step(1, 'h4000, pk(0, 0, 16'h0020, 16'h0013), 2, 0, 0, mk(2, 1, 1, 2, 2, 'h4000, pk(0, 0, 16'h0020, 16'h0013), 1));
    step(0, 0, 0, 0, 2, 0, mk(0, 1, 0, 0, 0, 'h4004, 0, 1));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_i);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #2 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
